// File: rtl/sram_stream_reader.sv
// Streams `length` consecutive SRAM words from `base_addr` as a valid/ready stream.
// Reads are issued against credits so the 2-entry output FIFO can never overflow.
module sram_stream_reader #(
  parameter int WORD_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [WORD_WIDTH-1:0] sram_q,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  rem_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;

  logic [WORD_WIDTH-1:0] mem_reg  [2];
  logic                  last_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_reg;

  // Entries that will be held once this cycle's pop and the word already in flight settle.
  assign occ   = {1'b0, count_reg} + {2'b0, inflight_reg} - {2'b0, pop};
  assign issue = (state_reg == READ) && (occ < 3'd2);

  assign sram_cen  = ~issue;
  assign sram_wen  = 1'b1;
  assign sram_addr = addr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_data  = mem_reg[rd_ptr_reg];
  assign out_last  = out_valid & last_reg[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      rem_reg           <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (rem_reg == LEN_WIDTH'(1));
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            addr_reg <= base_addr;
            rem_reg  <= length;
            busy_reg <= 1'b1;
            if (length == '0) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            rem_reg <= rem_reg - LEN_WIDTH'(1);
            // Hold the final address so an idle bus shows the last word read.
            if (rem_reg == LEN_WIDTH'(1)) state_reg <= DRAIN;
            else                          addr_reg  <= addr_reg + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_reg <= FINISH;
            done_reg  <= 1'b1;
          end
        end
        FINISH: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi]  <= '0;
          last_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi]  <= sram_q;
          last_reg[gi] <= inflight_last_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: SRAM model, stream monitor and per-transfer checks.
module tb_sram_stream_reader;

  localparam int WW = 256;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy, done, sram_cen, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [WW-1:0] sram_q;
  logic [WW-1:0] out_data;
  logic          out_valid, out_ready, out_last;

  sram_stream_reader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_q(sram_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] pat(input int a);
    logic [31:0] w;
    w = 32'(a);
    return {4{w, ~w}};
  endfunction

  logic [WW-1:0] sram_mem [1024];
  initial for (int i = 0; i < 1024; i++) sram_mem[i] = pat(i);
  always @(posedge clk) if (!sram_cen) sram_q <= sram_mem[sram_addr];

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observation state, cleared at each transfer start
  int            addr_q[$];
  logic [WW-1:0] data_q[$];
  logic          last_q[$];
  int            busy_cycles, valid_cycles, done_count;
  int            start_cyc, first_valid_cyc, first_cen_cyc, last_cen_cyc, last_hs_cyc, done_cyc;
  logic          hold_pending = 1'b0;
  logic [WW-1:0] held_data;
  logic          held_last;
  logic          bp_mode = 1'b0;
  logic [15:0]   bp_pat = 16'b0101_1100_1001_1001;

  task automatic clear_obs();
    addr_q.delete(); data_q.delete(); last_q.delete();
    busy_cycles = 0; valid_cycles = 0; done_count = 0;
    first_valid_cyc = -1; first_cen_cyc = -1; last_cen_cyc = -1; last_hs_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", WW'(out_valid), WW'(1'b1));
        check("hold_data", out_data, held_data);
        check("hold_last", WW'(out_last), WW'(held_last));
      end
      hold_pending = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      busy_cycles += int'(busy);
      valid_cycles += int'(out_valid);
      done_count += int'(done);
      if (!sram_cen) begin
        addr_q.push_back(int'(sram_addr));
        if (first_cen_cyc < 0) first_cen_cyc = cyc;
        last_cen_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        data_q.push_back(out_data);
        last_q.push_back(out_last);
        last_hs_cyc = cyc;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        out_ready = bp_pat[0];
        bp_pat = {bp_pat[0], bp_pat[15:1]};
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic start_xfer(input int b, input int len);
    @(posedge clk); #1;
    clear_obs();
    start = 1'b1; base_addr = AW'(b); length = LW'(len);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < bound);
    check("done_seen", WW'(done), WW'(1'b1));
    done_cyc = cyc;
  endtask

  task automatic verify(input string tag, input int b, input int len);
    check({tag, "_nwords"}, WW'(data_q.size()), WW'(len));
    check({tag, "_nreads"}, WW'(addr_q.size()), WW'(len));
    check({tag, "_no_extra_valid"}, WW'(out_valid), WW'(1'b0));
    for (int i = 0; i < len && i < data_q.size() && i < addr_q.size(); i++) begin
      check({tag, "_addr"}, WW'(addr_q[i]), WW'((b + i) % 1024));
      check({tag, "_data"}, data_q[i], pat((b + i) % 1024));
      check({tag, "_last"}, WW'(last_q[i]), WW'(i == len - 1));
    end
    $display("xfer %s base=%0d len=%0d words=%0d reads=%0d", tag, b, len, data_q.size(), addr_q.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, WW'(busy), '0);
    check({tag, "_done"}, WW'(done), '0);
    check({tag, "_cen"}, WW'(sram_cen), WW'(1'b1));
    check({tag, "_wen"}, WW'(sram_wen), WW'(1'b1));
    check({tag, "_addr"}, WW'(sram_addr), '0);
    check({tag, "_valid"}, WW'(out_valid), '0);
    check({tag, "_last"}, WW'(out_last), '0);
    check({tag, "_data"}, out_data, '0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic: back-to-back reads and words, fixed latency
    start_xfer(5, 4);
    wait_done(100);
    verify("basic", 5, 4);
    check("basic_first_valid_lat", WW'(first_valid_cyc - start_cyc), WW'(3));
    check("basic_reads_b2b", WW'(last_cen_cyc - first_cen_cyc), WW'(3));
    check("basic_done_lat", WW'(done_cyc - last_hs_cyc), WW'(1));
    @(negedge clk);
    check("basic_done_pulse", WW'(done), '0);
    check("basic_busy_low", WW'(busy), '0);
    check("basic_done_count", WW'(done_count), WW'(1));

    // Backpressure
    bp_mode = 1'b1;
    start_xfer(0, 8);
    wait_done(200);
    verify("bp", 0, 8);
    bp_mode = 1'b0;

    // Zero length
    start_xfer(77, 0);
    wait_done(20);
    check("zero_done_lat", WW'(done_cyc - start_cyc), WW'(1));
    check("zero_nreads", WW'(addr_q.size()), '0);
    check("zero_valid_cycles", WW'(valid_cycles), '0);
    @(negedge clk);
    check("zero_busy_cycles", WW'(busy_cycles), WW'(1));

    // Address wrap
    start_xfer(1022, 4);
    wait_done(100);
    verify("wrap", 1022, 4);

    // Start while busy is ignored; start right after done is accepted
    start_xfer(100, 6);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = AW'(200); length = LW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    verify("busy_start", 100, 6);
    start_xfer(400, 3);
    wait_done(100);
    verify("after_done", 400, 3);

    // Full depth
    start_xfer(0, 1024);
    wait_done(3000);
    verify("full", 0, 1024);

    // Reset mid-transfer
    start_xfer(300, 6);
    n = 0;
    while (addr_q.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_3", WW'(addr_q.size() >= 3), WW'(1'b1));
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    repeat (4) @(negedge clk);
    check("post_reset_no_valid", WW'(valid_cycles), '0);
    check("post_reset_no_reads", WW'(addr_q.size()), '0);
    start_xfer(50, 2);
    wait_done(100);
    verify("post_reset", 50, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
